// File: rtl/cpu_bus_pkg.sv
// Shared types and timing constants for the Famicom CPU bus master.
// Both NTSC (9/15) and Dendy (10/14) M2 timing sets are provided.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    IDLE_HI = 2'd1,
    ACC_LO  = 2'd2,
    ACC_HI  = 2'd3
  } bus_state_e;

  localparam int PHASE_CNT_W = 6;

  localparam int NTSC_M2_LOW_CYC   = 9;
  localparam int NTSC_M2_HIGH_CYC  = 15;
  localparam int DENDY_M2_LOW_CYC  = 10;
  localparam int DENDY_M2_HIGH_CYC = 14;

  localparam int DEF_ROMSEL_DLY = 2;
  localparam int DEF_WDATA_DLY  = 1;

endpackage

// File: rtl/m2_phase_gen.sv
// Free-running M2 generator. Strobes and idx_o are look-ahead: they describe the
// clk that follows the coming edge, so the master can register its pins directly.
module m2_phase_gen
  import cpu_bus_pkg::*;
#(
  parameter int M2_LOW_CYC  = NTSC_M2_LOW_CYC,
  parameter int M2_HIGH_CYC = NTSC_M2_HIGH_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   m2_o,
  output logic                   phase_hi_o,
  output logic                   first_lo_o,
  output logic                   first_hi_o,
  output logic                   last_hi_o,
  output logic [PHASE_CNT_W-1:0] idx_o
);

  localparam logic [PHASE_CNT_W-1:0] LO_LAST = PHASE_CNT_W'(M2_LOW_CYC - 1);
  localparam logic [PHASE_CNT_W-1:0] HI_LAST = PHASE_CNT_W'(M2_HIGH_CYC - 1);

  logic                   m2_q, m2_d;
  logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    m2_d  = m2_q;
    cnt_d = cnt_q + PHASE_CNT_W'(1);
    if (!m2_q && cnt_q == LO_LAST) begin
      m2_d  = 1'b1;
      cnt_d = '0;
    end else if (m2_q && cnt_q == HI_LAST) begin
      m2_d  = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      m2_q  <= m2_d;
      cnt_q <= cnt_d;
    end
  end

  assign m2_o       = m2_q;
  assign phase_hi_o = m2_d;
  assign first_lo_o = !m2_d && (cnt_d == '0);
  assign first_hi_o = m2_d && (cnt_d == '0);
  assign last_hi_o  = m2_d && (cnt_d == HI_LAST);
  assign idx_o      = cnt_d;

endmodule

// File: rtl/famicom_cpu_bus_master.sv
// Console-side Famicom CPU bus initiator: one request per M2 period, all pins registered.
// Optional CPU_BUS_MASTER_IRQ_EN adds a synchronized, per-period sampled irq_sync.
module famicom_cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int M2_LOW_CYC  = NTSC_M2_LOW_CYC,
  parameter int M2_HIGH_CYC = NTSC_M2_HIGH_CYC,
  parameter int ROMSEL_DLY  = DEF_ROMSEL_DLY,
  parameter int WDATA_DLY   = DEF_WDATA_DLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        m2,
  output logic        romsel,
  output logic        cpu_rw,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_oe,
  input  logic [7:0]  cpu_data_in,
  input  logic        irq,
  output logic        irq_sync
);

  logic                   phase_hi, first_lo, first_hi, last_hi;
  logic [PHASE_CNT_W-1:0] idx;

  m2_phase_gen #(
    .M2_LOW_CYC (M2_LOW_CYC),
    .M2_HIGH_CYC(M2_HIGH_CYC)
  ) u_phase (
    .clk       (clk),
    .rst_n     (rst_n),
    .m2_o      (m2),
    .phase_hi_o(phase_hi),
    .first_lo_o(first_lo),
    .first_hi_o(first_hi),
    .last_hi_o (last_hi),
    .idx_o     (idx)
  );

  bus_state_e  state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        romsel_q, romsel_d;
  logic        cpu_rw_q, cpu_rw_d;
  logic [14:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        a15_q, a15_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        accept;

  // req_ready_q is high exactly on the last HIGH clk, so it doubles as the bus-cycle boundary.
  assign accept = req_valid && req_ready_q;

  always_comb begin
    state_d     = state_q;
    req_ready_d = last_hi;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    romsel_d    = romsel_q;
    cpu_rw_d    = cpu_rw_q;
    cpu_addr_d  = cpu_addr_q;
    dout_d      = dout_q;
    oe_d        = oe_q;
    a15_d       = a15_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;

    // Write data is held exactly one clk into the LOW phase.
    if (oe_q && !m2) oe_d = 1'b0;

    if (first_lo) begin
      romsel_d = 1'b1;
      if (state_q == ACC_HI) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = wr_q ? 8'h00 : cpu_data_in;
      end
      if (accept) begin
        state_d    = ACC_LO;
        cpu_addr_d = req_addr[14:0];
        cpu_rw_d   = !req_write;
        a15_d      = req_addr[15];
        wr_d       = req_write;
        wdata_d    = req_wdata;
      end else begin
        state_d  = IDLE_LO;
        cpu_rw_d = 1'b1;
      end
    end else if (first_hi) begin
      state_d = (state_q == ACC_LO) ? ACC_HI : IDLE_HI;
    end

    if (state_d == ACC_HI && phase_hi) begin
      if (a15_q && idx == PHASE_CNT_W'(ROMSEL_DLY)) romsel_d = 1'b0;
      if (wr_q && idx == PHASE_CNT_W'(WDATA_DLY)) begin
        oe_d   = 1'b1;
        dout_d = wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE_LO;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      romsel_q    <= 1'b1;
      cpu_rw_q    <= 1'b1;
      cpu_addr_q  <= 15'h0000;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
      a15_q       <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= 8'h00;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      romsel_q    <= romsel_d;
      cpu_rw_q    <= cpu_rw_d;
      cpu_addr_q  <= cpu_addr_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      a15_q       <= a15_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign romsel       = romsel_q;
  assign cpu_rw       = cpu_rw_q;
  assign cpu_addr     = cpu_addr_q;
  assign cpu_data_out = dout_q;
  assign cpu_data_oe  = oe_q;

`ifdef CPU_BUS_MASTER_IRQ_EN
  logic irq_s1_q, irq_s2_q, irq_sync_q;

  // Like the 6502, the level is only looked at once per period, on the last HIGH clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1_q   <= 1'b1;
      irq_s2_q   <= 1'b1;
      irq_sync_q <= 1'b1;
    end else begin
      irq_s1_q <= irq;
      irq_s2_q <= irq_s1_q;
      if (req_ready_q) irq_sync_q <= irq_s2_q;
    end
  end

  assign irq_sync = irq_sync_q;
`else
  logic irq_unused;
  assign irq_unused = irq;
  assign irq_sync   = 1'b1;
`endif

endmodule
